uart_tx_fifo: RTL and testbench
===============================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 4, meaning FIFO depth of 2^DEPTH_LOG2 bytes.
REQ-002 SHALL have parameter START_TIMEOUT, default 7, meaning max cycles to wait for tx_busy to rise after a send request.
REQ-003 clk  in  1  system clock; all logic on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 wr_en  in  1  push wr_data this cycle.
REQ-006 wr_data  in  8  byte to queue.
REQ-007 full  out  1  FIFO holds 2^DEPTH_LOG2 bytes.
REQ-008 empty  out  1  FIFO holds 0 bytes.
REQ-009 count  out  DEPTH_LOG2+1  bytes currently stored.
REQ-010 tx_data  out  8  byte presented to the UART transmitter data input.
REQ-011 tx_send  out  1  one-cycle send request to the UART transmitter.
REQ-012 tx_busy  in  1  UART transmission-in-progress flag.
REQ-013 overflow  out  1  sticky flag: a push was dropped.
REQ-014 start_err  out  1  sticky flag: tx_busy failed to rise within START_TIMEOUT.

Function
REQ-015 SHALL store bytes in arrival order; circular read/write pointers, DEPTH_LOG2 bits each, wrap modulo depth.
REQ-016 Push SHALL occur when wr_en=1 and (full=0 or a pop occurs in the same cycle).
REQ-017 wr_en=1 with full=1 and no same-cycle pop SHALL drop the byte, leave count unchanged, and set overflow.
REQ-018 Simultaneous push and pop SHALL leave count unchanged, including at full and at empty+1.
REQ-019 full, empty and count SHALL be registered and reflect the state after the edge that changed them.
REQ-020 Scheduler FSM states: IDLE, ISSUE, WAIT_START, WAIT_DONE.
REQ-021 IDLE: if empty=0 and tx_busy=0, pop the head into tx_data and go to ISSUE; otherwise stay.
REQ-022 ISSUE: tx_send=1 for exactly this cycle, tx_data stable; next state WAIT_START, timeout counter cleared.
REQ-023 WAIT_START: tx_busy=1 -> WAIT_DONE; counter reaching START_TIMEOUT -> set start_err, go to IDLE (byte is lost, not re-queued).
REQ-024 WAIT_DONE: tx_busy=0 -> IDLE; otherwise stay.
REQ-025 tx_data SHALL hold its value from ISSUE until the next pop.
REQ-026 Latency: push into an empty FIFO with tx_busy=0 SHALL produce tx_send 2 cycles after the wr_en edge.
REQ-027 At most one byte in flight; no tx_send while state is not IDLE->ISSUE.
REQ-028 A push in the same cycle the FIFO becomes empty SHALL be accepted and scheduled normally.

Reset
REQ-029 rst=1 SHALL, at the next edge, set pointers and count to 0, empty=1, full=0, tx_send=0, tx_data=0x00, overflow=0, start_err=0, FSM=IDLE.
REQ-030 Reset mid-transmission SHALL discard queued and in-flight bytes; wr_en is ignored during rst.

Configuration
REQ-031 Macro UART_TX_FIFO_ERR_FLAGS_EN defined: overflow and start_err behave per REQ-017/REQ-023.
REQ-032 Macro undefined: overflow and start_err are tied to 0, no sticky registers; drop and timeout behaviour unchanged.

Structure
REQ-033 Shared package uart_pkg SHALL hold the FSM state encodings (2 bits) and default DEPTH_LOG2/START_TIMEOUT constants.
REQ-034 Storage SHALL be a sub-module uart_fifo_mem (synchronous-write, combinational-read byte array) so it infers as block RAM or registers.

Verification
REQ-035 Push 0x55 into empty FIFO, tx_busy raised 2 cycles after tx_send for 10 cycles -> tx_send pulse 2 cycles after push, tx_data=0x55, count returns 0.
REQ-036 Push 0x01..0x10 back-to-back (depth 16) with tx_busy held 1 -> full=1, count=16; extra push 0xAA -> dropped, overflow=1, count=16.
REQ-037 Full FIFO, push and pop same cycle -> count stays 16, pushed byte emerges last in order.
REQ-038 Push 0x3C, tx_busy never rises -> start_err=1 after 7 WAIT_START cycles, FSM IDLE, next queued byte issued.
REQ-039 Assert rst with 5 bytes queued while tx_busy=1 -> next cycle count=0, empty=1, tx_send=0, flags cleared.
REQ-040 Build without UART_TX_FIFO_ERR_FLAGS_EN, repeat REQ-036 -> overflow stays 0, byte still dropped.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared scheduler state encoding and default sizing for the UART TX FIFO
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_ISSUE      = 2'd1,
    ST_WAIT_START = 2'd2,
    ST_WAIT_DONE  = 2'd3
  } tx_state_t;

  localparam int DEFAULT_DEPTH_LOG2    = 4;
  localparam int DEFAULT_START_TIMEOUT = 7;

endpackage

// File: rtl/uart_fifo_mem.sv
// rtl/uart_fifo_mem.sv - byte storage array, synchronous write and combinational read
module uart_fifo_mem #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdata
);

  logic [7:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO that schedules one byte at a time into a UART transmitter
// Define UART_TX_FIFO_ERR_FLAGS_EN to get sticky overflow/start_err flags; otherwise both read 0.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2    = DEFAULT_DEPTH_LOG2,
  parameter int START_TIMEOUT = DEFAULT_START_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [7:0]            wr_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic [7:0]            tx_data,
  output logic                  tx_send,
  input  logic                  tx_busy,
  output logic                  overflow,
  output logic                  start_err
);

  localparam int TO_W = $clog2(START_TIMEOUT + 1);
  localparam logic [TO_W-1:0]     TO_LAST  = TO_W'(START_TIMEOUT - 1);
  localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  tx_state_t             state, state_next;
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]   count_next;
  logic [TO_W-1:0]       to_cnt;
  logic [7:0]            head;
  logic                  push, pop;

  // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
  assign push    = wr_en && (!full || pop);
  assign tx_send = (state == ST_ISSUE);

  uart_fifo_mem #(.ADDR_W(DEPTH_LOG2)) u_mem (
    .clk   (clk),
    .we    (push && !rst),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .raddr (rd_ptr),
    .rdata (head)
  );

  always_comb begin
    count_next = count;
    if (push && !pop)      count_next = count + 1'b1;
    else if (pop && !push) count_next = count - 1'b1;
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!empty && !tx_busy) begin
          pop        = 1'b1;
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE:      state_next = ST_WAIT_START;
      ST_WAIT_START: begin
        if (tx_busy)                 state_next = ST_WAIT_DONE;
        else if (to_cnt == TO_LAST)  state_next = ST_IDLE;
      end
      ST_WAIT_DONE:  if (!tx_busy) state_next = ST_IDLE;
      default:       state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      empty   <= 1'b1;
      full    <= 1'b0;
      tx_data <= 8'h00;
      to_cnt  <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
      empty <= (count_next == '0);
      full  <= (count_next == FULL_CNT);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        tx_data <= head;
      end
      if (state == ST_ISSUE)           to_cnt <= '0;
      else if (state == ST_WAIT_START) to_cnt <= to_cnt + 1'b1;
    end
  end

`ifdef UART_TX_FIFO_ERR_FLAGS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      start_err <= 1'b0;
    end else begin
      if (wr_en && full && !pop) overflow <= 1'b1;
      if (state == ST_WAIT_START && !tx_busy && to_cnt == TO_LAST) start_err <= 1'b1;
    end
  end
`else
  assign overflow  = 1'b0;
  assign start_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed self-checking bench for uart_tx_fifo
module tb_uart_tx_fifo;

`ifdef UART_TX_FIFO_ERR_FLAGS_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, wr_en, tx_busy;
  logic [7:0] wr_data;
  logic       full, empty, tx_send, overflow, start_err;
  logic [4:0] count;
  logic [7:0] tx_data;

  int tests  = 0;
  int errors = 0;

  uart_tx_fifo #(.DEPTH_LOG2(4), .START_TIMEOUT(7)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .tx_data   (tx_data),
    .tx_send   (tx_send),
    .tx_busy   (tx_busy),
    .overflow  (overflow),
    .start_err (start_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Waits for the next send request, checks the byte, then plays a short busy window.
  task automatic serve(input logic [7:0] exp, input string name);
    int n = 0;
    while (tx_send !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    tests++;
    if (tx_send !== 1'b1) begin
      errors++;
      $display("FAIL %s: tx_send never rose, got %b want 1", name, tx_send);
    end else if (tx_data !== exp) begin
      errors++;
      $display("FAIL %s: tx_data got %h want %h", name, tx_data, exp);
    end
    tick();
    tx_busy = 1'b1;
    tick();
    tx_busy = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; tx_busy = 1'b0;
    tick(); tick();
    tests++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
    tests++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", empty); end
    tests++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", full); end
    tests++; if (tx_send !== 1'b0) begin errors++; $display("FAIL reset_tx_send: got %b want 0", tx_send); end
    tests++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
    tests++; if ({overflow, start_err} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b want 00", {overflow, start_err}); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    wr_en = 1'b1; wr_data = 8'h55;
    tick();
    wr_en = 1'b0;
    tests++; if (count !== 5'd1 || empty !== 1'b0) begin errors++; $display("FAIL single_count1: got count %0d empty %b want 1 0", count, empty); end
    tests++; if (tx_send !== 1'b0) begin errors++; $display("FAIL single_early_send: got %b want 0", tx_send); end
    tick();
    tests++; if (tx_send !== 1'b1 || tx_data !== 8'h55) begin errors++; $display("FAIL single_send: got send %b data %h want 1 55", tx_send, tx_data); end
    tests++; if (count !== 5'd0 || empty !== 1'b1) begin errors++; $display("FAIL single_count0: got count %0d empty %b want 0 1", count, empty); end
    tick();
    tests++; if (tx_send !== 1'b0) begin errors++; $display("FAIL single_pulse_width: got %b want 0", tx_send); end
    tx_busy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      tests++; if (tx_send !== 1'b0) begin errors++; $display("FAIL single_busy_send: cycle %0d got %b want 0", i, tx_send); end
    end
    tx_busy = 1'b0;
    tick(); tick();
    tests++; if (tx_data !== 8'h55 || tx_send !== 1'b0) begin errors++; $display("FAIL single_hold: got data %h send %b want 55 0", tx_data, tx_send); end
    tests++; if (start_err !== 1'b0) begin errors++; $display("FAIL single_start_err: got %b want 0", start_err); end
  endtask

  task automatic test_fill_overflow();
    tx_busy = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      wr_en = 1'b1; wr_data = 8'(i);
      tick();
    end
    wr_en = 1'b0;
    tests++; if (full !== 1'b1 || count !== 5'd16) begin errors++; $display("FAIL fill_full: got full %b count %0d want 1 16", full, count); end
    tests++; if (overflow !== 1'b0) begin errors++; $display("FAIL fill_no_overflow: got %b want 0", overflow); end
    wr_en = 1'b1; wr_data = 8'hAA;
    tick();
    wr_en = 1'b0;
    tests++; if (count !== 5'd16 || full !== 1'b1) begin errors++; $display("FAIL drop_count: got count %0d full %b want 16 1", count, full); end
    tests++; if (overflow !== ERR_EN) begin errors++; $display("FAIL drop_overflow: got %b want %b", overflow, ERR_EN); end
  endtask

  task automatic test_full_push_pop();
    tx_busy = 1'b0; wr_en = 1'b1; wr_data = 8'hBB;
    tick();
    wr_en = 1'b0;
    tests++; if (count !== 5'd16 || full !== 1'b1) begin errors++; $display("FAIL pushpop_count: got count %0d full %b want 16 1", count, full); end
    serve(8'h01, "pushpop_first");
    for (int i = 2; i <= 16; i++) serve(8'(i), $sformatf("order_%0d", i));
    serve(8'hBB, "order_last");
    tests++; if (count !== 5'd0 || empty !== 1'b1) begin errors++; $display("FAIL drain_empty: got count %0d empty %b want 0 1", count, empty); end
  endtask

  task automatic test_start_timeout();
    tx_busy = 1'b0;
    wr_en = 1'b1; wr_data = 8'h3C;
    tick();
    wr_data = 8'h7E;
    tick();
    wr_en = 1'b0;
    tests++; if (tx_send !== 1'b1 || tx_data !== 8'h3C) begin errors++; $display("FAIL to_send: got send %b data %h want 1 3c", tx_send, tx_data); end
    tests++; if (count !== 5'd1) begin errors++; $display("FAIL to_pushpop_count: got %0d want 1", count); end
    repeat (7) tick();
    tests++; if (start_err !== 1'b0 || tx_send !== 1'b0) begin errors++; $display("FAIL to_early: got err %b send %b want 0 0", start_err, tx_send); end
    tick();
    tests++; if (start_err !== ERR_EN || tx_send !== 1'b0) begin errors++; $display("FAIL to_flag: got err %b send %b want %b 0", start_err, tx_send, ERR_EN); end
    tick();
    tests++; if (tx_send !== 1'b1 || tx_data !== 8'h7E || count !== 5'd0) begin errors++; $display("FAIL to_next: got send %b data %h count %0d want 1 7e 0", tx_send, tx_data, count); end
    serve(8'h7E, "to_next_serve");
  endtask

  task automatic test_reset_mid();
    tx_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_data = 8'hA1 + 8'(i);
      tick();
    end
    wr_en = 1'b0;
    tests++; if (count !== 5'd5) begin errors++; $display("FAIL mid_count5: got %0d want 5", count); end
    rst = 1'b1; wr_en = 1'b1; wr_data = 8'hEE;
    tick();
    tests++; if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL mid_reset_fifo: got count %0d empty %b full %b want 0 1 0", count, empty, full); end
    tests++; if (tx_send !== 1'b0 || tx_data !== 8'h00) begin errors++; $display("FAIL mid_reset_tx: got send %b data %h want 0 00", tx_send, tx_data); end
    tests++; if ({overflow, start_err} !== 2'b00) begin errors++; $display("FAIL mid_reset_flags: got %b want 00", {overflow, start_err}); end
    rst = 1'b0; wr_en = 1'b0; tx_busy = 1'b0;
    tick(); tick();
    tests++; if (tx_send !== 1'b0 || empty !== 1'b1) begin errors++; $display("FAIL mid_no_ghost: got send %b empty %b want 0 1", tx_send, empty); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_overflow();
    test_full_push_pop();
    test_start_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
